// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = 3;
    localparam logic        RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_BYTE     = 2'b00,
        SEL_HALF     = 2'b01,
        SEL_WORD     = 2'b10,
        SEL_WORD_ALT = 2'b11
    } size_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Number of bytes moved for a MEM access size code.
    function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] sel);
        case (size_t'(sel))
            SEL_BYTE: return CNT_W'(1);
            SEL_HALF: return CNT_W'(2);
            default:  return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates MEM and IF requests and serialises each access onto an 8-bit
// single-port RAM, one byte per cycle, little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t              state;
    owner_t              owner;
    logic [CNT_W-1:0]    nbytes;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   base;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rd_buf;

    owner_t              req_own_c;
    logic                req_we_c;
    logic [CNT_W-1:0]    req_n_c;
    logic [ADDR_W-1:0]   req_addr_c;
    logic [DATA_W-1:0]   req_wdata_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [1:0]          cap_lane_c;
    logic [1:0]          nxt_lane_c;
    logic [ADDR_W-1:0]   next_addr_c;
    logic [DATA_W-1:0]   capt_c;
    logic                unused_addr_bits;

    // Address bits above the RAM width are deliberately ignored.
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Fixed-priority request selection: MEM wins over IF.
    always_comb begin
        req_own_c   = OWN_IF;
        req_we_c    = 1'b0;
        req_n_c     = CNT_W'(4);
        req_addr_c  = if_addr[ADDR_W-1:0];
        req_wdata_c = '0;
        if (mem_req) begin
            req_own_c   = OWN_MEM;
            req_we_c    = mem_we;
            req_n_c     = size_bytes(mem_sel);
            req_addr_c  = mem_addr[ADDR_W-1:0];
            req_wdata_c = mem_wdata;
        end
    end

    assign cnt_inc_c   = cnt + CNT_W'(1);
    assign cap_lane_c  = 2'(cnt - CNT_W'(1));
    assign nxt_lane_c  = 2'(cnt_inc_c);
    assign next_addr_c = base + ADDR_W'(cnt_inc_c);

    // Read data arrives one cycle after its address, so cnt-1 is the lane landing now.
    always_comb begin
        capt_c = rd_buf;
        capt_c[{cap_lane_c, 3'b000} +: BYTE_W] = ram_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            nbytes    <= '0;
            cnt       <= '0;
            base      <= '0;
            wdata     <= '0;
            rd_buf    <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_wr <= 1'b0;
                    if (mem_req || if_req) begin
                        owner    <= req_own_c;
                        nbytes   <= req_n_c;
                        base     <= req_addr_c;
                        wdata    <= req_wdata_c;
                        cnt      <= '0;
                        rd_buf   <= '0;
                        ram_addr <= req_addr_c;
                        if (req_we_c) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= req_wdata_c[BYTE_W-1:0];
                            state    <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    cnt <= cnt_inc_c;
                    if (cnt != '0) rd_buf <= capt_c;
                    if (cnt == nbytes) begin
                        state <= DONE;
                        if (owner == OWN_MEM) begin
                            mem_done  <= 1'b1;
                            mem_rdata <= capt_c;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= capt_c;
                        end
                    end else begin
                        ram_addr <= next_addr_c;
                    end
                end
                WRITE: begin
                    if (cnt == nbytes - CNT_W'(1)) begin
                        ram_wr <= 1'b0;
                        state  <= DONE;
                        if (owner == OWN_MEM) mem_done <= 1'b1;
                        else                  if_done  <= 1'b1;
                    end else begin
                        cnt      <= cnt_inc_c;
                        ram_addr <= next_addr_c;
                        ram_dout <= wdata[{nxt_lane_c, 3'b000} +: BYTE_W];
                    end
                end
                DONE: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
